// File: rtl/yags_update_queue_pkg.sv
// Shared types for the YAGS branch update queue.
// Record layout, FSM states and counter write-back constants.
package yags_update_queue_pkg;

  localparam int UQ_PC_SIZE  = 10;
  localparam int UQ_GHR_SIZE = 10;

  typedef struct packed {
    logic [UQ_PC_SIZE-1:0]  pc;
    logic [UQ_GHR_SIZE-1:0] ghr;
    logic                   choice;
    logic                   dir_hit;
    logic                   dir_pred;
  } yags_rec_t;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    RECOVER
  } uq_state_e;

  localparam logic [1:0] CNT_WEAK_T  = 2'b10;
  localparam logic [1:0] CNT_WEAK_NT = 2'b01;

endpackage

// File: rtl/yags_update_queue_rec_fifo.sv
// Circular record FIFO with synchronous clear.
// Clear drops every entry by snapping rd_ptr onto wr_ptr.
module yags_rec_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 23
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  input  logic                     i_clr,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  // Entry storage, written on every accepted push
  always_ff @(posedge clk) begin
    if (i_push && !i_clr) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_rd_ptr <= r_wr_ptr;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      unique case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/yags_update_queue.sv
// In-order YAGS branch resolution queue.
// Pops the oldest branch, writes back PHTs, recovers GHR on mispredict.
module yags_update_queue
  import yags_update_queue_pkg::*;
#(
  parameter int QDEPTH   = 8,
  parameter int GHR_SIZE = 10,
  parameter int PC_SIZE  = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push_valid,
  output logic                push_ready,
  input  logic [PC_SIZE-1:0]  push_pc,
  input  logic [GHR_SIZE-1:0] push_ghr,
  input  logic                push_choice,
  input  logic                push_dir_hit,
  input  logic                push_dir_pred,
  input  logic                res_valid,
  output logic                res_ready,
  input  logic                res_taken,
  output logic [PC_SIZE-1:0]  upd_address,
  output logic [GHR_SIZE-1:0] upd_history,
  output logic [1:0]          upd_actual,
  output logic                choice_update,
  output logic                choice_taken,
  output logic                tc_update,
  output logic                tc_miss_predict,
  output logic                nt_update,
  output logic                nt_miss_predict,
  output logic                recover_valid,
  output logic [GHR_SIZE-1:0] recover_ghr,
  output logic                mispredict
);

  localparam int AW = $clog2(QDEPTH);
  localparam int EW = PC_SIZE + GHR_SIZE + 3;
  localparam logic [AW:0] LP_FULL = QDEPTH[AW:0];

  uq_state_e           r_state;
  logic                r_mis;
  logic [PC_SIZE-1:0]  r_upd_address;
  logic [GHR_SIZE-1:0] r_upd_history;
  logic [1:0]          r_upd_actual;
  logic                r_choice_update;
  logic                r_choice_taken;
  logic                r_tc_update;
  logic                r_tc_mp;
  logic                r_nt_update;
  logic                r_nt_mp;
  logic                r_recover_valid;
  logic [GHR_SIZE-1:0] r_recover_ghr;
  logic                r_mispredict;

  logic [EW-1:0]       w_head;
  logic [AW:0]         w_count;
  logic                w_push;
  logic                w_pop;
  logic                w_clr;
  logic [PC_SIZE-1:0]  w_h_pc;
  logic [GHR_SIZE-1:0] w_h_ghr;
  logic                w_h_choice;
  logic                w_h_hit;
  logic                w_h_pred;
  logic                w_final;
  logic                w_mis;
  logic                w_sel_upd;
  logic                w_sel_mp;
  logic                w_cu;

  assign push_ready = (w_count < LP_FULL) && (r_state != RECOVER);
  assign res_ready  = (r_state == IDLE) && (w_count != '0);
  assign w_push     = push_valid && push_ready;
  assign w_pop      = res_valid && res_ready;
  assign w_clr      = (r_state == RECOVER);

  yags_rec_fifo #(
    .DEPTH (QDEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  ({push_pc, push_ghr, push_choice,
               push_dir_hit, push_dir_pred}),
    .i_pop   (w_pop),
    .i_clr   (w_clr),
    .o_data  (w_head),
    .o_count (w_count)
  );

  assign w_h_pc     = w_head[EW-1 -: PC_SIZE];
  assign w_h_ghr    = w_head[3 +: GHR_SIZE];
  assign w_h_choice = w_head[2];
  assign w_h_hit    = w_head[1];
  assign w_h_pred   = w_head[0];

  // A direction-cache hit overrides the choice PHT
  assign w_final   = w_h_hit ? w_h_pred : w_h_choice;
  assign w_mis     = (w_final != res_taken);
  assign w_sel_upd = w_h_hit;
  assign w_sel_mp  = w_h_hit ? (w_h_pred != res_taken)
                             : (w_h_choice != res_taken);
  // Choice PHT is left alone when only the cache rescued it
  assign w_cu      = !(w_h_hit && (w_h_pred == res_taken)
                       && (w_h_choice != res_taken));

  // Resolve FSM with registered write-back and recovery outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_mis           <= 1'b0;
      r_upd_address   <= '0;
      r_upd_history   <= '0;
      r_upd_actual    <= '0;
      r_choice_update <= 1'b0;
      r_choice_taken  <= 1'b0;
      r_tc_update     <= 1'b0;
      r_tc_mp         <= 1'b0;
      r_nt_update     <= 1'b0;
      r_nt_mp         <= 1'b0;
      r_recover_valid <= 1'b0;
      r_recover_ghr   <= '0;
      r_mispredict    <= 1'b0;
    end else begin
      r_choice_update <= 1'b0;
      r_tc_update     <= 1'b0;
      r_tc_mp         <= 1'b0;
      r_nt_update     <= 1'b0;
      r_nt_mp         <= 1'b0;
      r_recover_valid <= 1'b0;
      r_mispredict    <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_state         <= WRITE;
            r_mis           <= w_mis;
            r_upd_address   <= w_h_pc;
            r_upd_history   <= w_h_ghr;
            r_upd_actual    <= res_taken ? CNT_WEAK_T
                                         : CNT_WEAK_NT;
            r_choice_update <= w_cu;
            r_choice_taken  <= res_taken;
            r_tc_update     <= !w_h_choice && w_sel_upd;
            r_tc_mp         <= !w_h_choice && w_sel_mp;
            r_nt_update     <= w_h_choice && w_sel_upd;
            r_nt_mp         <= w_h_choice && w_sel_mp;
            r_mispredict    <= w_mis;
          end
        end
        WRITE: begin
          if (r_mis) begin
            r_state         <= RECOVER;
            r_recover_valid <= 1'b1;
            r_recover_ghr   <= {r_upd_history[GHR_SIZE-2:0],
                                r_choice_taken};
          end else begin
            r_state <= IDLE;
          end
        end
        RECOVER: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign upd_address     = r_upd_address;
  assign upd_history     = r_upd_history;
  assign upd_actual      = r_upd_actual;
  assign choice_update   = r_choice_update;
  assign choice_taken    = r_choice_taken;
  assign tc_update       = r_tc_update;
  assign tc_miss_predict = r_tc_mp;
  assign nt_update       = r_nt_update;
  assign nt_miss_predict = r_nt_mp;
  assign recover_valid   = r_recover_valid;
  assign recover_ghr     = r_recover_ghr;
  assign mispredict      = r_mispredict;

endmodule

// File: tb/tb_yags_update_queue.sv
// Bench for yags_update_queue: table rows, directed corners,
// and random traffic against a queue-based reference model.
module tb_yags_update_queue;

  typedef struct packed {
    logic [9:0] pc;
    logic [9:0] ghr;
    logic       ch;
    logic       dh;
    logic       dp;
  } rec_t;

  typedef struct {
    logic ch, dh, dp, tk;
    logic cu, tcu, tcm, ntu, ntm, mis;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       push_valid;
  logic       push_ready;
  logic [9:0] push_pc;
  logic [9:0] push_ghr;
  logic       push_choice;
  logic       push_dir_hit;
  logic       push_dir_pred;
  logic       res_valid;
  logic       res_ready;
  logic       res_taken;
  logic [9:0] upd_address;
  logic [9:0] upd_history;
  logic [1:0] upd_actual;
  logic       choice_update;
  logic       choice_taken;
  logic       tc_update;
  logic       tc_miss_predict;
  logic       nt_update;
  logic       nt_miss_predict;
  logic       recover_valid;
  logic [9:0] recover_ghr;
  logic       mispredict;

  yags_update_queue #(
    .QDEPTH   (8),
    .GHR_SIZE (10),
    .PC_SIZE  (10)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .push_valid      (push_valid),
    .push_ready      (push_ready),
    .push_pc         (push_pc),
    .push_ghr        (push_ghr),
    .push_choice     (push_choice),
    .push_dir_hit    (push_dir_hit),
    .push_dir_pred   (push_dir_pred),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_taken       (res_taken),
    .upd_address     (upd_address),
    .upd_history     (upd_history),
    .upd_actual      (upd_actual),
    .choice_update   (choice_update),
    .choice_taken    (choice_taken),
    .tc_update       (tc_update),
    .tc_miss_predict (tc_miss_predict),
    .nt_update       (nt_update),
    .nt_miss_predict (nt_miss_predict),
    .recover_valid   (recover_valid),
    .recover_ghr     (recover_ghr),
    .mispredict      (mispredict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // reference model state
  rec_t       mq[$];
  int         m_phase;
  logic       m_mis;
  logic [9:0] e_addr, e_hist, e_rg;
  logic [1:0] e_act;
  logic       e_cu, e_ct, e_tcu, e_tcm, e_ntu, e_ntm;
  logic       e_rv, e_mis;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      if (failures < 40)
        $display("FAIL %s: got 0x%0h want 0x%0h at %0t",
                 nm, act, exp, $time);
    end
  endtask

  function automatic logic m_pr();
    return (mq.size() < 8) && (m_phase != 2);
  endfunction

  function automatic logic m_rr();
    return (m_phase == 0) && (mq.size() != 0);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_phase = 0; m_mis = 0;
    e_addr = 0; e_hist = 0; e_rg = 0; e_act = 0;
    e_cu = 0; e_ct = 0; e_tcu = 0; e_tcm = 0;
    e_ntu = 0; e_ntm = 0; e_rv = 0; e_mis = 0;
  endtask

  task automatic model_step(input logic rst, input logic pv,
                            input rec_t r, input logic rv,
                            input logic tk);
    logic pr, rr, fin, su, sm;
    rec_t h;
    if (rst) begin
      model_reset();
      return;
    end
    pr = m_pr();
    rr = m_rr();
    e_cu = 0; e_tcu = 0; e_tcm = 0; e_ntu = 0; e_ntm = 0;
    e_rv = 0; e_mis = 0;
    case (m_phase)
      0: if (rv && rr) begin
        h   = mq.pop_front();
        fin = h.dh ? h.dp : h.ch;
        m_mis = (fin != tk);
        su  = h.dh;
        sm  = h.dh ? (h.dp != tk) : (h.ch != tk);
        if (h.ch) begin e_ntu = su; e_ntm = sm; end
        else      begin e_tcu = su; e_tcm = sm; end
        e_cu   = !(h.dh && h.dp == tk && h.ch != tk);
        e_ct   = tk;
        e_act  = tk ? 2'b10 : 2'b01;
        e_addr = h.pc;
        e_hist = h.ghr;
        e_mis  = m_mis;
        m_phase = 1;
      end
      1: begin
        if (m_mis) begin
          e_rv = 1;
          e_rg = {e_hist[8:0], e_ct};
          m_phase = 2;
        end else begin
          m_phase = 0;
        end
      end
      default: begin
        mq.delete();
        m_phase = 0;
      end
    endcase
    if (pv && pr) mq.push_back(r);
  endtask

  task automatic compare_all();
    chk("push_ready", 32'(push_ready), 32'(m_pr()));
    chk("res_ready", 32'(res_ready), 32'(m_rr()));
    chk("upd_address", 32'(upd_address), 32'(e_addr));
    chk("upd_history", 32'(upd_history), 32'(e_hist));
    chk("upd_actual", 32'(upd_actual), 32'(e_act));
    chk("choice_update", 32'(choice_update), 32'(e_cu));
    chk("choice_taken", 32'(choice_taken), 32'(e_ct));
    chk("tc_update", 32'(tc_update), 32'(e_tcu));
    chk("tc_miss_predict", 32'(tc_miss_predict), 32'(e_tcm));
    chk("nt_update", 32'(nt_update), 32'(e_ntu));
    chk("nt_miss_predict", 32'(nt_miss_predict), 32'(e_ntm));
    chk("recover_valid", 32'(recover_valid), 32'(e_rv));
    chk("recover_ghr", 32'(recover_ghr), 32'(e_rg));
    chk("mispredict", 32'(mispredict), 32'(e_mis));
  endtask

  // drive one cycle from a negedge, then land on the next negedge
  task automatic tick(input logic rst, input logic pv, input rec_t r,
                      input logic rv, input logic tk);
    rst_n         = !rst;
    push_valid    = pv;
    push_pc       = r.pc;
    push_ghr      = r.ghr;
    push_choice   = r.ch;
    push_dir_hit  = r.dh;
    push_dir_pred = r.dp;
    res_valid     = rv;
    res_taken     = tk;
    model_step(rst, pv, r, rv, tk);
    @(negedge clk);
    compare_all();
  endtask

  function automatic rec_t mk(input int pc, input int ghr,
                              input logic ch, input logic dh,
                              input logic dp);
    rec_t r;
    r.pc = 10'(pc); r.ghr = 10'(ghr);
    r.ch = ch; r.dh = dh; r.dp = dp;
    return r;
  endfunction

  function automatic rec_t rnd_rec();
    return mk(int'($urandom_range(0, 1023)),
              int'($urandom_range(0, 1023)),
              1'($urandom), 1'($urandom), 1'($urandom));
  endfunction

  vec_t vt[9];
  rec_t z;

  initial begin
    z = '0;
    rst_n = 0; push_valid = 0; push_pc = 0; push_ghr = 0;
    push_choice = 0; push_dir_hit = 0; push_dir_pred = 0;
    res_valid = 0; res_taken = 0;
    model_reset();

    //       ch dh dp tk  cu tcu tcm ntu ntm mis
    vt[0] = '{1, 0, 0, 1, 1, 0, 0, 0, 0, 0};
    vt[1] = '{1, 0, 0, 0, 1, 0, 0, 0, 1, 1};
    vt[2] = '{0, 1, 1, 1, 0, 1, 0, 0, 0, 0};
    vt[3] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    vt[4] = '{0, 0, 0, 1, 1, 0, 1, 0, 0, 1};
    vt[5] = '{1, 1, 0, 0, 0, 0, 0, 1, 0, 0};
    vt[6] = '{1, 1, 0, 1, 1, 0, 0, 1, 1, 1};
    vt[7] = '{0, 1, 0, 1, 1, 1, 1, 0, 0, 1};
    vt[8] = '{1, 1, 1, 1, 1, 0, 0, 1, 0, 0};

    @(negedge clk);
    tick(1, 0, z, 0, 0);
    tick(1, 0, z, 0, 0);
    chk("rst push_ready", 32'(push_ready), 1);
    chk("rst res_ready", 32'(res_ready), 0);
    chk("rst upd_actual", 32'(upd_actual), 0);
    chk("rst recover_valid", 32'(recover_valid), 0);

    // fill to full
    for (int i = 0; i < 8; i++)
      tick(0, 1, mk(i, i, 0, 0, 0), 0, 0);
    chk("full push_ready", 32'(push_ready), 0);
    tick(0, 1, mk(99, 99, 0, 0, 0), 0, 0);
    chk("full9 push_ready", 32'(push_ready), 0);
    chk("full9 res_ready", 32'(res_ready), 1);
    tick(1, 0, z, 0, 0);

    // correct choice, no cache hit
    tick(0, 1, mk('h0A4, 'h155, 1, 0, 0), 0, 0);
    tick(0, 0, z, 1, 1);
    chk("d1 choice_update", 32'(choice_update), 1);
    chk("d1 choice_taken", 32'(choice_taken), 1);
    chk("d1 upd_actual", 32'(upd_actual), 2);
    chk("d1 upd_address", 32'(upd_address), 'h0A4);
    chk("d1 nt_miss_predict", 32'(nt_miss_predict), 0);
    chk("d1 mispredict", 32'(mispredict), 0);
    tick(0, 0, z, 0, 0);
    chk("d1 recover_valid", 32'(recover_valid), 0);

    // choice wrong -> NT allocate and recovery
    tick(0, 1, mk('h0A4, 'h155, 1, 0, 0), 0, 0);
    tick(0, 0, z, 1, 0);
    chk("d2 nt_miss_predict", 32'(nt_miss_predict), 1);
    chk("d2 upd_actual", 32'(upd_actual), 1);
    chk("d2 mispredict", 32'(mispredict), 1);
    tick(0, 0, z, 0, 0);
    chk("d2 recover_valid", 32'(recover_valid), 1);
    chk("d2 recover_ghr", 32'(recover_ghr), 'h2AA);
    tick(0, 0, z, 0, 0);
    chk("d2 empty", 32'(res_ready), 0);

    // T-cache hit rescues wrong choice
    tick(0, 1, mk(7, 'h033, 0, 1, 1), 0, 0);
    tick(0, 0, z, 1, 1);
    chk("d3 tc_update", 32'(tc_update), 1);
    chk("d3 tc_miss_predict", 32'(tc_miss_predict), 0);
    chk("d3 choice_update", 32'(choice_update), 0);
    chk("d3 mispredict", 32'(mispredict), 0);
    tick(0, 0, z, 0, 0);

    // table rows
    for (int i = 0; i < 9; i++) begin
      tick(0, 1, mk(16 + i, 3 * i, vt[i].ch, vt[i].dh, vt[i].dp),
           0, 0);
      tick(0, 0, z, 1, vt[i].tk);
      chk($sformatf("row%0d cu", i), 32'(choice_update), 32'(vt[i].cu));
      chk($sformatf("row%0d tcu", i), 32'(tc_update), 32'(vt[i].tcu));
      chk($sformatf("row%0d tcm", i), 32'(tc_miss_predict),
          32'(vt[i].tcm));
      chk($sformatf("row%0d ntu", i), 32'(nt_update), 32'(vt[i].ntu));
      chk($sformatf("row%0d ntm", i), 32'(nt_miss_predict),
          32'(vt[i].ntm));
      chk($sformatf("row%0d mis", i), 32'(mispredict), 32'(vt[i].mis));
      tick(0, 0, z, 0, 0);
      chk($sformatf("row%0d rv", i), 32'(recover_valid), 32'(vt[i].mis));
      tick(0, 0, z, 0, 0);
    end

    // squash including a push accepted during WRITE
    for (int i = 0; i < 3; i++)
      tick(0, 1, mk(40 + i, i, 1, 0, 0), 0, 0);
    tick(0, 0, z, 1, 0);
    chk("sq write push_ready", 32'(push_ready), 1);
    tick(0, 1, mk(50, 1, 0, 0, 0), 0, 0);
    chk("sq rec push_ready", 32'(push_ready), 0);
    chk("sq rec recover_valid", 32'(recover_valid), 1);
    tick(0, 1, mk(51, 2, 0, 0, 0), 0, 0);
    chk("sq idle push_ready", 32'(push_ready), 1);
    chk("sq idle res_ready", 32'(res_ready), 0);

    // reset during WRITE
    tick(0, 1, mk(60, 5, 1, 0, 0), 0, 0);
    tick(0, 0, z, 1, 0);
    chk("rw mispredict", 32'(mispredict), 1);
    tick(1, 0, z, 0, 0);
    chk("rw recover_valid", 32'(recover_valid), 0);
    chk("rw res_ready", 32'(res_ready), 0);
    chk("rw upd_address", 32'(upd_address), 0);
    chk("rw mispredict0", 32'(mispredict), 0);
    tick(0, 0, z, 0, 0);
    chk("rw2 recover_valid", 32'(recover_valid), 0);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      tick(($urandom % 256) == 0, 1'($urandom), rnd_rec(),
           1'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
